// File: rtl/free_list_ring.sv
// Circular free list of physical tags with speculative and committed heads for register renaming.
// Optional duplicate-release detection is enabled by defining FREELIST_DUP_CHECK_EN.
module free_list_ring #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned DEPTH    = NUM_PHYS - NUM_ARCH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             SYS_INIT,
    input  logic             alloc_req_IN,
    output logic             alloc_valid_OUT,
    output logic [TAG_W-1:0] alloc_tag_OUT,
    input  logic             commit_IN,
    input  logic             release_valid_IN,
    input  logic [TAG_W-1:0] release_tag_IN,
    input  logic             flush_IN,
    output logic [TAG_W:0]   free_count_OUT,
    output logic             full_OUT,
    output logic             error_OUT
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    ptr_t             tail_q, tail_d;
    ptr_t             spec_head_q, spec_head_d;
    ptr_t             commit_head_q, commit_head_d;
    logic             error_q, error_d;

    ptr_t             spec_free;
    ptr_t             commit_used;
    logic             alloc_ok;
    logic             commit_ok;
    logic             release_ok;

`ifdef FREELIST_DUP_CHECK_EN
    logic [NUM_PHYS-1:0] is_free_q, is_free_d;
    ptr_t                flush_cnt;
    ptr_t                flush_ptr;
`endif

    always_comb begin
        spec_free   = tail_q - spec_head_q;
        commit_used = tail_q - commit_head_q;
    end

    assign free_count_OUT  = (TAG_W+1)'(spec_free);
    assign alloc_valid_OUT = (spec_free != '0);
    assign full_OUT        = (commit_used == ptr_t'(DEPTH));
    assign alloc_tag_OUT   = mem_q[spec_head_q[IDX_W-1:0]];
    assign error_OUT       = error_q;

    always_comb begin
        mem_d         = mem_q;
        tail_d        = tail_q;
        commit_head_d = commit_head_q;
        error_d       = error_q;

        alloc_ok   = alloc_req_IN && alloc_valid_OUT && !flush_IN;
        commit_ok  = commit_IN && (commit_head_q != spec_head_q);
`ifdef FREELIST_DUP_CHECK_EN
        release_ok = release_valid_IN && !full_OUT && !is_free_q[release_tag_IN];
`else
        release_ok = release_valid_IN && !full_OUT;
`endif

        if (alloc_req_IN && !alloc_valid_OUT && !flush_IN) error_d = 1'b1;
        if (commit_IN && !commit_ok)                       error_d = 1'b1;
        if (release_valid_IN && !release_ok)               error_d = 1'b1;

        if (commit_ok) commit_head_d = commit_head_q + ptr_t'(1);
        if (release_ok) begin
            mem_d[tail_q[IDX_W-1:0]] = release_tag_IN;
            tail_d                   = tail_q + ptr_t'(1);
        end

        // Flush restores to the committed head after this cycle's commit.
        spec_head_d = flush_IN ? commit_head_d : spec_head_q + ptr_t'(alloc_ok);

`ifdef FREELIST_DUP_CHECK_EN
        is_free_d = is_free_q;
        flush_cnt = spec_head_q - commit_head_d;
        flush_ptr = commit_head_d;
        if (alloc_ok)   is_free_d[alloc_tag_OUT]  = 1'b0;
        if (release_ok) is_free_d[release_tag_IN] = 1'b1;
        if (flush_IN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                flush_ptr = commit_head_d + ptr_t'(i);
                if (ptr_t'(i) < flush_cnt) is_free_d[mem_q[flush_ptr[IDX_W-1:0]]] = 1'b1;
            end
        end
`endif

        if (SYS_INIT) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = TAG_W'(NUM_ARCH + i);
            tail_d        = ptr_t'(DEPTH);
            spec_head_d   = '0;
            commit_head_d = '0;
            error_d       = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
            for (int unsigned i = 0; i < NUM_PHYS; i++) is_free_d[i] = (i >= NUM_ARCH);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(NUM_ARCH + i);
            tail_q        <= ptr_t'(DEPTH);
            spec_head_q   <= '0;
            commit_head_q <= '0;
            error_q       <= 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
            for (int unsigned i = 0; i < NUM_PHYS; i++) is_free_q[i] <= (i >= NUM_ARCH);
`endif
        end else begin
            mem_q         <= mem_d;
            tail_q        <= tail_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            error_q       <= error_d;
`ifdef FREELIST_DUP_CHECK_EN
            is_free_q     <= is_free_d;
`endif
        end
    end

endmodule

// File: tb/tb_free_list_ring.sv
// Scoreboard bench for free_list_ring: a queue-based free-list model predicts outputs after each edge.
module tb_free_list_ring;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int TAG_W    = 6;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
`ifdef FREELIST_DUP_CHECK_EN
    localparam int FLUSH_REL_TAG = 32;
`else
    localparam int FLUSH_REL_TAG = 40;
`endif

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             SYS_INIT = 1'b0;
    logic             alloc_req_IN = 1'b0;
    logic             commit_IN = 1'b0;
    logic             release_valid_IN = 1'b0;
    logic [TAG_W-1:0] release_tag_IN = '0;
    logic             flush_IN = 1'b0;
    logic             alloc_valid_OUT;
    logic [TAG_W-1:0] alloc_tag_OUT;
    logic [TAG_W:0]   free_count_OUT;
    logic             full_OUT;
    logic             error_OUT;

    free_list_ring #(
        .NUM_PHYS (NUM_PHYS),
        .NUM_ARCH (NUM_ARCH),
        .TAG_W    (TAG_W),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .SYS_INIT         (SYS_INIT),
        .alloc_req_IN     (alloc_req_IN),
        .alloc_valid_OUT  (alloc_valid_OUT),
        .alloc_tag_OUT    (alloc_tag_OUT),
        .commit_IN        (commit_IN),
        .release_valid_IN (release_valid_IN),
        .release_tag_IN   (release_tag_IN),
        .flush_IN         (flush_IN),
        .free_count_OUT   (free_count_OUT),
        .full_OUT         (full_OUT),
        .error_OUT        (error_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int valid;
        int tag;
        int count;
        int full;
        int err;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   step_no = 0;

    // Reference model: tags waiting to be handed out, and tags handed out but not yet retired.
    int   free_q[$];
    int   spec_q[$];
    bit   m_err;
`ifdef FREELIST_DUP_CHECK_EN
    bit   m_free [NUM_PHYS];
`endif

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = NUM_ARCH; i < NUM_PHYS; i++) free_q.push_back(i);
        m_err = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
        for (int i = 0; i < NUM_PHYS; i++) m_free[i] = (i >= NUM_ARCH);
`endif
    endtask

    task automatic model_step(input bit a, input bit c, input bit r, input int t, input bit f);
        bit full_pre, avail, c_ok, r_ok;
        int tg;
        full_pre = (free_q.size() + spec_q.size()) == DEPTH;
        avail    = free_q.size() != 0;
        c_ok     = spec_q.size() != 0;
        r_ok     = !full_pre;
`ifdef FREELIST_DUP_CHECK_EN
        if (m_free[t]) r_ok = 1'b0;
`endif
        if (a && !f && !avail) m_err = 1'b1;
        if (c && !c_ok)        m_err = 1'b1;
        if (r && !r_ok)        m_err = 1'b1;
        if (c && c_ok) void'(spec_q.pop_front());
        if (a && !f && avail) begin
            tg = free_q.pop_front();
            spec_q.push_back(tg);
`ifdef FREELIST_DUP_CHECK_EN
            m_free[tg] = 1'b0;
`endif
        end
        if (r && r_ok) begin
            free_q.push_back(t);
`ifdef FREELIST_DUP_CHECK_EN
            m_free[t] = 1'b1;
`endif
        end
        if (f) begin
            for (int i = spec_q.size() - 1; i >= 0; i--) begin
                free_q.push_front(spec_q[i]);
`ifdef FREELIST_DUP_CHECK_EN
                m_free[spec_q[i]] = 1'b1;
`endif
            end
            spec_q.delete();
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.valid = (free_q.size() != 0);
        e.tag   = e.valid ? free_q[0] : 0;
        e.count = free_q.size();
        e.full  = ((free_q.size() + spec_q.size()) == DEPTH);
        e.err   = m_err;
        e.step  = step_no;
        return e;
    endfunction

    task automatic drive(input bit a, input bit c, input bit r, input int t, input bit f, input bit init);
        @(negedge CLK);
        alloc_req_IN     = a;
        commit_IN        = c;
        release_valid_IN = r;
        release_tag_IN   = TAG_W'(t);
        flush_IN         = f;
        SYS_INIT         = init;
        if (init) model_reset();
        else      model_step(a, c, r, t, f);
        step_no++;
        exp_q.push_back(model_outputs());
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int step, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, step, act, want);
        end
    endtask

    // Monitor: compares DUT outputs after each edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("alloc_valid", e.step, int'(alloc_valid_OUT), e.valid);
                if (alloc_valid_OUT && e.valid != 0) chk("alloc_tag", e.step, int'(alloc_tag_OUT), e.tag);
                chk("free_count", e.step, int'(free_count_OUT), e.count);
                chk("full", e.step, int'(full_OUT), e.full);
                chk("error", e.step, int'(error_OUT), e.err);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        @(negedge CLK);
        RESET_N = 1'b1;

        // Reset state seen through an idle cycle
        idle();

        // Drain all 32 tags, then one allocation too many
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle();

        // Retire everything and free tag 5
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 5, 0, 0);
        idle();

        // Flush after one commit returns the uncommitted tags
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle();

        // Flush with allocate, commit and release in one cycle, then drain to reach the released tag
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 1, 1, FLUSH_REL_TAG, 1, 0);
        for (int i = 0; i < DEPTH - 1; i++) drive(1, 0, 0, 0, 0, 0);
        idle();

        // Release while full
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 10, 0, 0);
        idle();

        // Release of a tag that is already free
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 40, 0, 0);
        idle();

        // Asynchronous reset in the middle of traffic
        drive(1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        alloc_req_IN = 1'b0;
        RESET_N = 1'b0;
        model_reset();
        step_no++;
        exp_q.push_back(model_outputs());
        @(negedge CLK);
        RESET_N = 1'b1;
        idle();

        // Randomized traffic with periodic re-initialisation
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(49) == 0) begin
                drive(0, 0, 0, 0, 0, 1);
            end else begin
                drive($urandom_range(99) < 60, $urandom_range(99) < 35, $urandom_range(99) < 35,
                      $urandom_range(NUM_PHYS - 1), $urandom_range(99) < 4, 0);
            end
        end
        idle();

        begin : drain
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(negedge CLK);
                budget--;
            end
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
